vga_sync_decoder: RTL and testbench

VGA_SYNC_DECODER -- requirements
Module: vga_sync_decoder

---
 rtl/vga_sync_pkg.sv | 20 ++
 rtl/sync_edge_detect.sv | 29 ++
 rtl/vga_sync_decoder.sv | 146 ++++++++++++++
 tb/tb_vga_sync_decoder.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_sync_pkg.sv
// Shared types and defaults for the VGA sync decoder.
// Counter widths are sized for 640x480 timing.
package vga_sync_pkg;

    typedef enum logic [1:0] {
        S_SEARCH,
        S_MEASURE,
        S_LOCKED
    } state_t;

    localparam int DEF_H_ACTIVE    = 640;
    localparam int DEF_V_ACTIVE    = 480;
    localparam int DEF_LOCK_FRAMES = 2;

    localparam int X_W = 10;
    localparam int Y_W = 9;
    localparam int A_W = 19;
    localparam int G_W = 4;

endpackage

// File: rtl/sync_edge_detect.sv
// Registers one sync input and flags its edges against the
// previous registered sample.
module sync_edge_detect #(
    parameter logic IDLE = 1'b0
) (
    input  logic iVGA_CLK,
    input  logic iRST,
    input  logic d,
    output logic q,
    output logic rise,
    output logic fall
);

    logic q_d;

    always_ff @(posedge iVGA_CLK) begin
        if (iRST) begin
            q   <= IDLE;
            q_d <= IDLE;
        end else begin
            q   <= d;
            q_d <= q;
        end
    end

    assign rise = q & ~q_d;
    assign fall = ~q & q_d;

endmodule

// File: rtl/vga_sync_decoder.sv
// Recovers pixel coordinates and a linear address from VGA
// sync/blank, and locks once the timing matches H/V_ACTIVE.
module vga_sync_decoder
    import vga_sync_pkg::*;
#(
    parameter int H_ACTIVE    = DEF_H_ACTIVE,
    parameter int V_ACTIVE    = DEF_V_ACTIVE,
    parameter int LOCK_FRAMES = DEF_LOCK_FRAMES
) (
    input  logic           iVGA_CLK,
    input  logic           iRST,
    input  logic           iHS,
    input  logic           iVS,
    input  logic           iBLANK_n,
    output logic [X_W-1:0] oX,
    output logic [Y_W-1:0] oY,
    output logic [A_W-1:0] oADDR,
    output logic           oPIX_VALID,
    output logic           oFRAME_START,
    output logic           oLOCKED,
    output logic           oERR
);

    logic hs_q, hs_rise, hs_fall;
    logic vs_q, vs_rise, vs_fall;
    logic bl_q, bl_rise, bl_fall;

    sync_edge_detect #(.IDLE(1'b1)) u_hs (
        .iVGA_CLK(iVGA_CLK), .iRST(iRST), .d(iHS),
        .q(hs_q), .rise(hs_rise), .fall(hs_fall)
    );

    sync_edge_detect #(.IDLE(1'b1)) u_vs (
        .iVGA_CLK(iVGA_CLK), .iRST(iRST), .d(iVS),
        .q(vs_q), .rise(vs_rise), .fall(vs_fall)
    );

    sync_edge_detect #(.IDLE(1'b0)) u_bl (
        .iVGA_CLK(iVGA_CLK), .iRST(iRST), .d(iBLANK_n),
        .q(bl_q), .rise(bl_rise), .fall(bl_fall)
    );

    // HS is registered for future line checks only
    logic unused_sync;
    assign unused_sync = ^{hs_q, hs_rise, hs_fall, vs_q, vs_rise};

    state_t         state, state_n;
    logic [G_W-1:0] good_cnt, good_n;
    logic [X_W-1:0] x_cnt, x_n, cur_x;
    logic [Y_W-1:0] line_cnt, line_n, cur_y;
    logic [A_W-1:0] addr_cnt, addr_n, cur_a;
    logic           viol, err;

    // frame clear wins over a same-cycle blank rise
    always_comb begin
        cur_x  = bl_rise ? '0 : x_cnt;
        cur_y  = vs_fall ? '0 : line_cnt;
        cur_a  = vs_fall ? '0 : addr_cnt;
        x_n    = x_cnt;
        line_n = cur_y;
        addr_n = cur_a;
        if (bl_q) begin
            x_n    = (&cur_x) ? cur_x : cur_x + X_W'(1);
            addr_n = (&cur_a) ? cur_a : cur_a + A_W'(1);
        end
        if (bl_fall)
            line_n = (&cur_y) ? cur_y : cur_y + Y_W'(1);
        viol = (bl_q && cur_x >= X_W'(H_ACTIVE))
            || (bl_q && cur_y >= Y_W'(V_ACTIVE))
            || (bl_fall && x_cnt < X_W'(H_ACTIVE))
            || (vs_fall && line_cnt != Y_W'(V_ACTIVE));
        err = viol && (state != S_SEARCH);
    end

    always_comb begin
        state_n = state;
        good_n  = good_cnt;
        unique case (state)
            S_SEARCH: begin
                if (vs_fall) begin
                    state_n = S_MEASURE;
                    good_n  = '0;
                end
            end
            S_MEASURE: begin
                if (viol) begin
                    state_n = S_SEARCH;
                    good_n  = '0;
                end else if (vs_fall) begin
                    good_n = good_cnt + G_W'(1);
                    if (good_n >= G_W'(LOCK_FRAMES))
                        state_n = S_LOCKED;
                end
            end
            S_LOCKED: begin
                if (viol) begin
                    state_n = S_SEARCH;
                    good_n  = '0;
                end
            end
            default: begin
                state_n = S_SEARCH;
                good_n  = '0;
            end
        endcase
    end

    always_ff @(posedge iVGA_CLK) begin
        if (iRST) begin
            state    <= S_SEARCH;
            good_cnt <= '0;
        end else begin
            state    <= state_n;
            good_cnt <= good_n;
        end
    end

    always_ff @(posedge iVGA_CLK) begin
        if (iRST) begin
            x_cnt        <= '0;
            line_cnt     <= '0;
            addr_cnt     <= '0;
            oX           <= '0;
            oY           <= '0;
            oADDR        <= '0;
            oPIX_VALID   <= 1'b0;
            oFRAME_START <= 1'b0;
            oERR         <= 1'b0;
        end else begin
            x_cnt        <= x_n;
            line_cnt     <= line_n;
            addr_cnt     <= addr_n;
            oFRAME_START <= vs_fall;
            oERR         <= err;
            oPIX_VALID   <= bl_q && !viol && (state == S_LOCKED);
            if (bl_q) begin
                oX    <= cur_x;
                oY    <= cur_y;
                oADDR <= cur_a;
            end
        end
    end

    assign oLOCKED = (state == S_LOCKED);

endmodule

// File: tb/tb_vga_sync_decoder.sv
// Self-checking bench for vga_sync_decoder at 8x4, two-frame lock.
// A frame-level reference model predicts every output cycle.
module tb_vga_sync_decoder;

    localparam int H = 8;
    localparam int V = 4;
    localparam int L = 2;

    logic        clk = 1'b0;
    logic        iRST, iHS, iVS, iBLANK_n;
    logic [9:0]  oX;
    logic [8:0]  oY;
    logic [18:0] oADDR;
    logic        oPIX_VALID, oFRAME_START, oLOCKED, oERR;

    always #5 clk = ~clk;

    vga_sync_decoder #(
        .H_ACTIVE(H), .V_ACTIVE(V), .LOCK_FRAMES(L)
    ) dut (
        .iVGA_CLK(clk), .iRST(iRST), .iHS(iHS), .iVS(iVS),
        .iBLANK_n(iBLANK_n), .oX(oX), .oY(oY), .oADDR(oADDR),
        .oPIX_VALID(oPIX_VALID), .oFRAME_START(oFRAME_START),
        .oLOCKED(oLOCKED), .oERR(oERR)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int err_cnt  = 0;
    int fs_cnt   = 0;
    int seq      = 0;
    bit seq_on   = 0;

    // reference model: good-frame count (-1 = not tracking)
    int   m_good = -1;
    int   m_x = 0, m_line = 0, m_addr = 0;
    logic h1_vs = 1'b1, h1_bl = 1'b0;
    logic h2_vs = 1'b1, h2_bl = 1'b0;

    typedef struct {
        int nl;
        int badl;
        int badlen;
        int exp_err;
        int exp_lock;
    } sc_t;

    sc_t tbl[6];

    task automatic chk(input string nm, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s t=%0t got=%0d want=%0d", nm, $time, act, exp);
        end
    endtask

    function automatic logic rh();
        return 1'($urandom_range(0, 1));
    endfunction

    task automatic model_check();
        bit vsf, br, bf, act, viol, trk, was_locked;
        int ex, ey, ea;
        vsf  = h2_vs && !h1_vs;
        br   = !h2_bl && h1_bl;
        bf   = h2_bl && !h1_bl;
        act  = h1_bl;
        viol = 0;
        ex = 0; ey = 0; ea = 0;
        if (vsf) begin
            if (m_line != V) viol = 1;
            m_line = 0;
            m_addr = 0;
        end
        if (br) m_x = 0;
        if (act) begin
            if (m_x >= H || m_line >= V) viol = 1;
            ex = m_x; ey = m_line; ea = m_addr;
            m_x++;
            m_addr++;
        end
        if (bf) begin
            if (m_x < H) viol = 1;
            m_line++;
        end
        trk        = (m_good >= 0);
        was_locked = (m_good >= L);
        if (trk && viol) m_good = -1;
        else if (vsf) m_good = !trk ? 0 : (m_good < L ? m_good + 1 : m_good);
        chk("frame_start", oFRAME_START, vsf);
        chk("err", oERR, trk && viol);
        chk("locked", oLOCKED, m_good >= L);
        chk("pix_valid", oPIX_VALID, act && was_locked && !viol);
        if (act && was_locked && !viol) begin
            chk("x", oX, ex);
            chk("y", oY, ey);
            chk("addr", oADDR, ea);
        end
    endtask

    task automatic step(input logic s_hs, input logic s_vs, input logic s_bl);
        iRST = 1'b0;
        iHS = s_hs;
        iVS = s_vs;
        iBLANK_n = s_bl;
        @(posedge clk);
        #1;
        model_check();
        err_cnt += oERR;
        fs_cnt += oFRAME_START;
        if (seq_on && oPIX_VALID) begin
            chk("seq_addr", oADDR, seq);
            chk("seq_x", oX, seq % H);
            chk("seq_y", oY, seq / H);
            seq++;
        end
        h2_vs = h1_vs; h2_bl = h1_bl;
        h1_vs = s_vs;  h1_bl = s_bl;
    endtask

    task automatic rst_step();
        iRST = 1'b1;
        iHS = rh();
        iVS = rh();
        iBLANK_n = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_x", oX, 0);
        chk("rst_y", oY, 0);
        chk("rst_addr", oADDR, 0);
        chk("rst_valid", oPIX_VALID, 0);
        chk("rst_fs", oFRAME_START, 0);
        chk("rst_locked", oLOCKED, 0);
        chk("rst_err", oERR, 0);
        m_good = -1; m_x = 0; m_line = 0; m_addr = 0;
        h1_vs = 1'b1; h1_bl = 1'b0;
        h2_vs = 1'b1; h2_bl = 1'b0;
    endtask

    task automatic vs_pulse(input int vsw, input int bp);
        for (int i = 0; i < vsw; i++) step(rh(), 1'b0, 1'b0);
        for (int i = 0; i < bp; i++) step(rh(), 1'b1, 1'b0);
    endtask

    task automatic line(input int n, input int hb);
        for (int i = 0; i < n; i++) step(rh(), 1'b1, 1'b1);
        for (int i = 0; i < hb; i++) step(rh(), 1'b1, 1'b0);
    endtask

    task automatic frame(input int nl, input int badl, input int badlen,
                         input int vsw, input int bp, input int hb);
        vs_pulse(vsw, bp);
        for (int l = 0; l < nl; l++) line((l == badl) ? badlen : H, hb);
    endtask

    task automatic relock();
        for (int i = 0; i < 4; i++) frame(V, -1, H, 2, 2, 3);
    endtask

    initial begin
        tbl[0] = '{V,     -1, H,      0, 1};
        tbl[1] = '{V,      1, H + 1,  1, 0};
        tbl[2] = '{V,      2, H - 1,  1, 0};
        tbl[3] = '{V + 1, -1, H,      1, 0};
        tbl[4] = '{V - 1, -1, H,      1, 0};
        tbl[5] = '{V,      3, H + 4,  1, 0};

        iRST = 1'b1; iHS = 1'b1; iVS = 1'b1; iBLANK_n = 1'b0;
        rst_step();
        rst_step();

        // three clean frames: lock two cycles after the third VS fall
        fs_cnt = 0; err_cnt = 0;
        frame(V, -1, H, 2, 2, 3);
        frame(V, -1, H, 2, 2, 3);
        chk("lock_before3", oLOCKED, 0);
        step(rh(), 1'b0, 1'b0);
        chk("lock_1cyc", oLOCKED, 0);
        step(rh(), 1'b0, 1'b0);
        chk("lock_2cyc", oLOCKED, 1);
        chk("fs_3rd", oFRAME_START, 1);
        step(rh(), 1'b1, 1'b0);
        step(rh(), 1'b1, 1'b0);
        for (int l = 0; l < V; l++) line(H, 3);
        chk("fs_count", fs_cnt, 3);
        chk("clean_err", err_cnt, 0);

        // one locked frame: 32 sequential pixels
        seq = 0; seq_on = 1;
        frame(V, -1, H, 2, 2, 3);
        seq_on = 0;
        chk("pix_count", seq, H * V);

        // reset mid-line while locked
        relock();
        chk("pre_rst_lock", oLOCKED, 1);
        vs_pulse(2, 2);
        for (int i = 0; i < 3; i++) step(rh(), 1'b1, 1'b1);
        rst_step();
        err_cnt = 0;
        line(H - 3, 3);
        for (int l = 1; l < V; l++) line(H, 3);
        frame(V, -1, H, 2, 2, 3);
        frame(V, -1, H, 2, 2, 3);
        chk("rst_relock_early", oLOCKED, 0);
        vs_pulse(2, 2);
        chk("rst_relock", oLOCKED, 1);
        for (int l = 0; l < V; l++) line(H, 3);
        chk("rst_no_err", err_cnt, 0);

        // VS fall coinciding with the first pixel of a frame
        relock();
        err_cnt = 0;
        step(rh(), 1'b1, 1'b0);
        step(rh(), 1'b0, 1'b1);
        step(rh(), 1'b0, 1'b1);
        chk("co_fs", oFRAME_START, 1);
        chk("co_valid", oPIX_VALID, 1);
        chk("co_x", oX, 0);
        chk("co_y", oY, 0);
        chk("co_addr", oADDR, 0);
        for (int i = 0; i < H - 2; i++) step(rh(), 1'b1, 1'b1);
        for (int i = 0; i < 3; i++) step(rh(), 1'b1, 1'b0);
        for (int l = 1; l < V; l++) line(H, 3);
        frame(V, -1, H, 2, 2, 3);
        chk("co_no_err", err_cnt, 0);
        chk("co_locked", oLOCKED, 1);

        // scenario table, each applied from lock
        foreach (tbl[i]) begin
            relock();
            chk($sformatf("tbl%0d_pre_lock", i), oLOCKED, 1);
            err_cnt = 0;
            frame(tbl[i].nl, tbl[i].badl, tbl[i].badlen, 2, 2, 3);
            frame(V, -1, H, 2, 2, 3);
            chk($sformatf("tbl%0d_err", i), err_cnt, tbl[i].exp_err);
            chk($sformatf("tbl%0d_lock", i), oLOCKED, tbl[i].exp_lock);
        end

        // randomized traffic against the model
        for (int it = 0; it < 30; it++) begin
            int k;
            k = $urandom_range(0, 9);
            case (k)
                0: for (int i = 0; i < 40; i++) step(rh(), rh(), rh());
                1: begin
                    vs_pulse(2, 2);
                    line($urandom_range(1, H), 0);
                    rst_step();
                    line(H, 3);
                end
                2: frame(V, $urandom_range(0, V - 1), $urandom_range(5, 11),
                         $urandom_range(1, 3), $urandom_range(1, 3),
                         $urandom_range(1, 4));
                3: frame($urandom_range(2, 6), -1, H,
                         $urandom_range(1, 3), $urandom_range(1, 3),
                         $urandom_range(1, 4));
                default: frame(V, -1, H, $urandom_range(1, 3),
                               $urandom_range(1, 3), $urandom_range(1, 4));
            endcase
        end
        relock();
        chk("final_lock", oLOCKED, 1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
